// File: rtl/cpc_io_uart.sv
// ---------------------------------------------------------------------------
// cpc_io_uart
//   8N1 serial port that answers on the CPC expansion I/O bus.
//   Four byte-wide registers at BASE_ADDR[15:2]:
//     0 DATA    write -> TX FIFO, read <- RX FIFO head (pop on end of read)
//     1 STATUS  {tx_ie, rx_ie, tx_overflow, framing_err, tx_idle,
//                rx_overrun, tx_not_full, rx_not_empty}
//     2 DIV_LO  3 DIV_HI  clocks per serial bit (minimum 4)
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cpu_addr, io_dout Z80 address / write data
//   io_wr, io_rd      I/O strobes, held for several clocks per access
//   io_din            read data, 8'hFF whenever this block is not read
//   txd, rxd          serial out (idle high) / serial in (asynchronous)
//   irq               level interrupt
// ---------------------------------------------------------------------------

// Circular FIFO with one extra pointer bit to tell full from empty.
// Head is shown combinationally. A pop frees a slot within the same cycle,
// so a push to a full FIFO is accepted when a pop happens alongside it.
module cpc_io_uart_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] head_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         drop_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wp_q, rp_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign drop_o  = push_i & ~do_push;
   assign head_o  = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
   end
endmodule

module cpc_io_uart #(
   parameter logic [15:0] BASE_ADDR  = 16'hFBD0,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd555
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  io_dout,
   input  logic        io_wr,
   input  logic        io_rd,
   output logic [7:0]  io_din,
   output logic        txd,
   input  logic        rxd,
   output logic        irq
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_st_e;

   // ---------------- bus decode ----------------
   logic       sel, wr_lvl, rd_lvl, wr_q, rd_q, wr_evt, rd_evt;
   logic [1:0] rd_addr_q;
   logic       wr_data, wr_stat, wr_dlo, wr_dhi;

   assign sel    = (cpu_addr[15:2] == BASE_ADDR[15:2]);
   assign wr_lvl = sel & io_wr;
   assign rd_lvl = sel & io_rd;
   assign wr_evt = wr_lvl & ~wr_q;
   // Pop only once the strobe is gone so the CPU has latched the head byte.
   assign rd_evt = ~rd_lvl & rd_q;

   assign wr_data = wr_evt && (cpu_addr[1:0] == 2'd0);
   assign wr_stat = wr_evt && (cpu_addr[1:0] == 2'd1);
   assign wr_dlo  = wr_evt && (cpu_addr[1:0] == 2'd2);
   assign wr_dhi  = wr_evt && (cpu_addr[1:0] == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_addr_q <= 2'd0;
      end else begin
         wr_q <= wr_lvl;
         rd_q <= rd_lvl;
         // Remember which register was read; the address may move before
         // the falling edge of the strobe is seen.
         if (rd_lvl) rd_addr_q <= cpu_addr[1:0];
      end
   end

   // ---------------- control registers and flags ----------------
   logic [15:0] div_q, eff_div;
   logic        rx_ie_q, tx_ie_q, rx_ovr_q, frm_err_q, tx_ovf_q;
   logic        rx_ovr_set, frm_set, tx_ovf_set;

   assign eff_div = (div_q < 16'd4) ? 16'd4 : div_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= DIV_RESET;
         rx_ie_q   <= 1'b0;
         tx_ie_q   <= 1'b0;
         rx_ovr_q  <= 1'b0;
         frm_err_q <= 1'b0;
         tx_ovf_q  <= 1'b0;
      end else begin
         if (wr_dlo) div_q[7:0]  <= io_dout;
         if (wr_dhi) div_q[15:8] <= io_dout;
         if (wr_stat) begin
            rx_ie_q <= io_dout[6];
            tx_ie_q <= io_dout[7];
         end
         // A new event in the same cycle as a clear keeps the flag set.
         rx_ovr_q  <= (rx_ovr_q  & ~(wr_stat & io_dout[2])) | rx_ovr_set;
         frm_err_q <= (frm_err_q & ~(wr_stat & io_dout[4])) | frm_set;
         tx_ovf_q  <= (tx_ovf_q  & ~(wr_stat & io_dout[5])) | tx_ovf_set;
      end
   end

   // ---------------- FIFOs ----------------
   logic [7:0] tx_head, rx_head, rx_sh_q;
   logic       tx_empty, tx_full, tx_pop;
   logic       rx_empty, rx_full, rx_push, rx_pop;

   assign rx_pop = rd_evt && (rd_addr_q == 2'd0) && !rx_empty;

   cpc_io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_txf (
      .clk_i(clk), .reset_i(reset), .push_i(wr_data), .pop_i(tx_pop),
      .wdata_i(io_dout), .head_o(tx_head), .empty_o(tx_empty),
      .full_o(tx_full), .drop_o(tx_ovf_set)
   );

   cpc_io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rxf (
      .clk_i(clk), .reset_i(reset), .push_i(rx_push), .pop_i(rx_pop),
      .wdata_i(rx_sh_q), .head_o(rx_head), .empty_o(rx_empty),
      .full_o(rx_full), .drop_o(rx_ovr_set)
   );

   // ---------------- transmitter ----------------
   ser_st_e     tx_st_q, tx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        txd_q, txd_d, tx_end;

   assign tx_end = (tx_cnt_q == tx_len_q - 16'd1);

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_len_d = tx_len_q;
      tx_sh_d  = tx_sh_q;
      tx_bit_d = tx_bit_q;
      tx_pop   = 1'b0;
      case (tx_st_q)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_pop   = 1'b1;
               tx_sh_d  = tx_head;
               tx_st_d  = S_START;
               tx_cnt_d = 16'd0;
               tx_len_d = eff_div;
            end
         end
         S_START: begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_end) begin
               tx_st_d  = S_DATA;
               tx_cnt_d = 16'd0;
               tx_len_d = eff_div;
               tx_bit_d = 3'd0;
            end
         end
         S_DATA: begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_end) begin
               tx_cnt_d = 16'd0;
               tx_len_d = eff_div;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
            end
         end
         S_STOP: begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_end) begin
               // Chain straight into the next start bit when more is queued.
               if (!tx_empty) begin
                  tx_pop   = 1'b1;
                  tx_sh_d  = tx_head;
                  tx_st_d  = S_START;
                  tx_cnt_d = 16'd0;
                  tx_len_d = eff_div;
               end else begin
                  tx_st_d = S_IDLE;
               end
            end
         end
      endcase
      // txd is registered from the next state so the line is glitch free.
      case (tx_st_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = tx_sh_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_st_q  <= S_IDLE;
         tx_cnt_q <= 16'd0;
         tx_len_q <= 16'd4;
         tx_sh_q  <= 8'd0;
         tx_bit_q <= 3'd0;
         txd_q    <= 1'b1;
      end else begin
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_len_q <= tx_len_d;
         tx_sh_q  <= tx_sh_d;
         tx_bit_q <= tx_bit_d;
         txd_q    <= txd_d;
      end
   end

   // ---------------- receiver ----------------
   ser_st_e     rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
   logic [7:0]  rx_sh_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        rx_m_q, rxs_q, rxs_prev_q, rx_end, rx_mid;

   assign rx_end = (rx_cnt_q == rx_len_q - 16'd1);
   assign rx_mid = (rx_cnt_q == {1'b0, rx_len_q[15:1]});

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_len_d = rx_len_q;
      rx_sh_d  = rx_sh_q;
      rx_bit_d = rx_bit_q;
      rx_push  = 1'b0;
      frm_set  = 1'b0;
      case (rx_st_q)
         // Falling-edge detect also covers rearming after a framing error:
         // the line has to return high before a new edge can be seen.
         S_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               rx_st_d  = S_START;
               rx_cnt_d = 16'd0;
               rx_len_d = eff_div;
            end
         end
         S_START: begin
            rx_cnt_d = rx_cnt_q + 16'd1;
            if (rx_mid) begin
               if (rxs_q) begin
                  rx_st_d = S_IDLE;
               end else begin
                  rx_st_d  = S_DATA;
                  rx_cnt_d = 16'd0;
                  rx_len_d = eff_div;
                  rx_bit_d = 3'd0;
               end
            end
         end
         S_DATA: begin
            rx_cnt_d = rx_cnt_q + 16'd1;
            if (rx_end) begin
               rx_cnt_d = 16'd0;
               rx_len_d = eff_div;
               rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
            end
         end
         S_STOP: begin
            rx_cnt_d = rx_cnt_q + 16'd1;
            if (rx_end) begin
               rx_st_d = S_IDLE;
               if (rxs_q) rx_push = 1'b1;
               else       frm_set = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m_q     <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         rx_st_q    <= S_IDLE;
         rx_cnt_q   <= 16'd0;
         rx_len_q   <= 16'd4;
         rx_sh_q    <= 8'd0;
         rx_bit_q   <= 3'd0;
      end else begin
         rx_m_q     <= rxd;
         rxs_q      <= rx_m_q;
         rxs_prev_q <= rxs_q;
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_len_q   <= rx_len_d;
         rx_sh_q    <= rx_sh_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   // ---------------- outputs ----------------
   logic       tx_idle;
   logic [7:0] status;

   assign tx_idle = tx_empty && (tx_st_q == S_IDLE);
   assign status  = {tx_ie_q, rx_ie_q, tx_ovf_q, frm_err_q,
                     tx_idle, rx_ovr_q, ~tx_full, ~rx_empty};

   always_comb begin
      io_din = 8'hFF;
      if (sel && io_rd) begin
         case (cpu_addr[1:0])
            2'd0: io_din = rx_empty ? 8'h00 : rx_head;
            2'd1: io_din = status;
            2'd2: io_din = div_q[7:0];
            2'd3: io_din = div_q[15:8];
         endcase
      end
   end

   assign txd = txd_q;
   assign irq = (~rx_empty & rx_ie_q) | (tx_empty & tx_ie_q);
endmodule
